// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tristate bus built from tri_buffer stages.
// Drives one oe at a time, inserts a dead turnaround cycle between owners, and
// registers the resolved bus value for the downstream consumer.
module tri_bus_arbiter #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned ID_W     = 2,   // must equal clog2(NUM_SRC)
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_HOLD = 8    // 1..255 grant cycles per tenure
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] req,
    input  logic [WIDTH-1:0]   bus_in,
    output logic [NUM_SRC-1:0] grant_oe,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic [WIDTH-1:0]   bus_q,
    output logic               bus_valid,
    output logic [ID_W-1:0]    bus_src
);

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StGrant
    } state_e;

    localparam logic [7:0]      HoldLast = 8'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0] PtrInit  = ID_W'(NUM_SRC - 1);

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [7:0]      hold_cnt_q;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] scan_idx;

    // Pick the first requester after the last owner, wrapping modulo NUM_SRC.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        for (int k = int'(NUM_SRC); k >= 1; k--) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_SRC));
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Single FSM block; every output is a flop so req never reaches oe combinationally.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StIdle;
            grant_oe   <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            bus_q      <= '0;
            bus_valid  <= 1'b0;
            bus_src    <= '0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= PtrInit;
        end else begin
            bus_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req != '0) begin
                        grant_id <= winner;
                        busy     <= 1'b1;
                        state_q  <= StTurn;
                    end
                end
                StTurn: begin
                    if (req[grant_id]) begin
                        grant_oe   <= NUM_SRC'(1) << grant_id;
                        hold_cnt_q <= '0;
                        state_q    <= StGrant;
                    end else begin
                        // Requester vanished during turnaround: no tenure, pointer untouched.
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    // Every grant cycle is sampled, including the one where req drops.
                    bus_q     <= bus_in;
                    bus_src   <= grant_id;
                    bus_valid <= 1'b1;
                    if (req[grant_id] && (hold_cnt_q < HoldLast)) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end else begin
                        grant_oe   <= '0;
                        busy       <= 1'b0;
                        hold_cnt_q <= '0;
                        rr_ptr_q   <= grant_id;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    grant_oe <= '0;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed and random checks of tri_bus_arbiter against a tenure-level model.
module tb_tri_bus_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int ID_W     = 2;
    localparam int WIDTH    = 32;
    localparam int MAX_HOLD = 8;
    localparam int BOUND    = 3 * NUM_SRC * (MAX_HOLD + 2);

    logic               clock;
    logic               resetn;
    logic [NUM_SRC-1:0] req;
    logic [WIDTH-1:0]   bus_in;
    logic [NUM_SRC-1:0] grant_oe;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic [WIDTH-1:0]   bus_q;
    logic               bus_valid;
    logic [ID_W-1:0]    bus_src;

    logic [WIDTH-1:0]   src_data [NUM_SRC];

    int checks   = 0;
    int failures = 0;

    // Reference model state (phase: 0 idle, 1 turnaround, 2 owning)
    int               m_phase;
    int               m_ptr;
    int               m_done;
    logic [NUM_SRC-1:0] e_oe;
    int               e_id;
    logic             e_busy;
    logic [WIDTH-1:0] e_q;
    logic             e_valid;
    int               e_src;

    // Invariant trackers
    logic [NUM_SRC-1:0] prev_oe;
    int zero_run;
    bit stress_on;
    int wait_cnt [NUM_SRC];
    int max_wait;

    // Tenure recording
    int owners [$];
    int lens [$];
    int run_len;
    int run_owner;
    int cnt_a;
    int cnt_b;
    bit found;

    tri_bus_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W),
        .WIDTH   (WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req      (req),
        .bus_in   (bus_in),
        .grant_oe (grant_oe),
        .grant_id (grant_id),
        .busy     (busy),
        .bus_q    (bus_q),
        .bus_valid(bus_valid),
        .bus_src  (bus_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wired bus: the enabled source drives, otherwise it floats high.
    always_comb begin
        bus_in = 32'hFFFF_FFFF;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_oe[i]) bus_in = src_data[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NUM_SRC-1:0] r);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (r[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
        end
        return 0;
    endfunction

    function automatic int oh_idx(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_step();
        if (!resetn) begin
            m_phase = 0; m_ptr = NUM_SRC - 1; m_done = 0;
            e_oe = '0; e_id = 0; e_busy = 1'b0; e_q = '0; e_valid = 1'b0; e_src = 0;
        end else begin
            e_valid = 1'b0;
            case (m_phase)
                0: if (req != '0) begin
                    e_id = rr_pick(m_ptr, req);
                    e_busy = 1'b1;
                    m_phase = 1;
                end
                1: if (req[e_id]) begin
                    e_oe = NUM_SRC'(1) << e_id;
                    m_done = 0;
                    m_phase = 2;
                end else begin
                    e_busy = 1'b0;
                    m_phase = 0;
                end
                default: begin
                    e_q = src_data[e_id];
                    e_src = e_id;
                    e_valid = 1'b1;
                    m_done++;
                    if (!(req[e_id] && m_done < MAX_HOLD)) begin
                        e_oe = '0;
                        e_busy = 1'b0;
                        m_ptr = e_id;
                        m_done = 0;
                        m_phase = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        chk("grant_oe", 32'(grant_oe), 32'(e_oe));
        chk("grant_id", 32'(grant_id), 32'(e_id));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("bus_q", bus_q, e_q);
        chk("bus_valid", 32'(bus_valid), 32'(e_valid));
        chk("bus_src", 32'(bus_src), 32'(e_src));
        chk("onehot", 32'($countones(grant_oe) <= 1), 32'd1);
        chk("handover", 32'(grant_oe == '0 || prev_oe == '0 || grant_oe == prev_oe), 32'd1);
        if (prev_oe == '0 && grant_oe != '0) chk("dead_cycles", 32'(zero_run >= 2), 32'd1);
        if (grant_oe == '0) zero_run++;
        else zero_run = 0;
        prev_oe = grant_oe;
        if (stress_on) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (req[i] && !grant_oe[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    initial begin
        prev_oe = '0; zero_run = 2; stress_on = 1'b0; max_wait = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wait_cnt[i] = 0;
            src_data[i] = 32'h1000_0000 + 32'(i);
        end
        m_phase = 0; m_ptr = NUM_SRC - 1; m_done = 0;
        e_oe = '0; e_id = 0; e_busy = 1'b0; e_q = '0; e_valid = 1'b0; e_src = 0;

        // 1: reset with all requests raised
        resetn = 1'b0;
        req = 4'b1111;
        tick();
        tick();
        chk("rst_oe", 32'(grant_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_q", bus_q, 32'd0);
        resetn = 1'b1;
        req = 4'b0000;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // 2: single requester, three grant cycles
        src_data[2] = 32'hDEAD_BEEF;
        req = 4'b0100;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) req = 4'b0000;
            tick();
            if (c == 0) chk("single_turn", 32'({busy, grant_oe}), 32'b10000);
            if (grant_oe == 4'b0100) cnt_a++;
            if (bus_valid && bus_q == 32'hDEAD_BEEF && bus_src == 2'd2) cnt_b++;
        end
        chk("single_grant_cycles", 32'(cnt_a), 32'd3);
        chk("single_valid_cycles", 32'(cnt_b), 32'd3);

        // 3: round robin with every source requesting
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req = 4'b1111;
        run_len = 0; run_owner = -1;
        for (int c = 0; c < 51; c++) begin
            tick();
            if (grant_oe != '0) begin
                if (run_len == 0) run_owner = oh_idx(grant_oe);
                run_len++;
            end else if (run_len != 0) begin
                owners.push_back(run_owner);
                lens.push_back(run_len);
                run_len = 0;
            end
        end
        chk("rr_tenures", 32'(owners.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < owners.size(); i++) begin
            chk("rr_owner", 32'(owners[i]), 32'(i % NUM_SRC));
            chk("rr_len", 32'(lens[i]), 32'(MAX_HOLD));
        end

        // 4: one-cycle request aborts in turnaround
        resetn = 1'b0;
        req = 4'b0000;
        tick();
        resetn = 1'b1;
        req = 4'b0010;
        tick();
        chk("abort_turn_id", 32'(grant_id), 32'd1);
        chk("abort_turn_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        tick();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_oe", 32'(grant_oe), 32'd0);
        req = 4'b0011;
        tick();
        chk("abort_next_id", 32'(grant_id), 32'd0);
        tick();
        chk("abort_next_oe", 32'(grant_oe), 32'b0001);

        // 5: reset during the third grant cycle of source 3
        req = 4'b1000;
        src_data[3] = 32'hC0FF_EE03;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (grant_oe == 4'b1000) found = 1'b1;
        end
        chk("src3_granted", 32'(found), 32'd1);
        tick();
        tick();
        chk("src3_third", 32'(grant_oe), 32'b1000);
        resetn = 1'b0;
        req = 4'b1111;
        tick();
        chk("midrst_oe", 32'(grant_oe), 32'd0);
        chk("midrst_valid", 32'(bus_valid), 32'd0);
        resetn = 1'b1;
        tick();
        chk("midrst_first_id", 32'(grant_id), 32'd0);
        tick();
        chk("midrst_first_oe", 32'(grant_oe), 32'b0001);

        // 6: random request stress
        resetn = 1'b0;
        req = '0;
        tick();
        resetn = 1'b1;
        stress_on = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, NUM_SRC - 1)] ^= 1'b1;
            for (int i = 0; i < NUM_SRC; i++) src_data[i] = $urandom;
            tick();
        end
        chk("starvation_bound", 32'(max_wait <= BOUND), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
